// File: rtl/fir_host_pkg.sv
// Shared definitions for the fir_array_host endpoint.
//   NIB_W     : width of one serial nibble on the array links
//   calc_nf() : frame length in nibbles for a given result width
//   nibble_t  : one nibble as carried on Xin/Yin/Xout/Yout
//   tx_state_e: transmit FSM states
package fir_host_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAPW
  } tx_state_e;

  function automatic int calc_nf(input int y_w);
    return y_w / NIB_W;
  endfunction

endpackage

// File: rtl/fir_host_fifo.sv
// Synchronous result FIFO for fir_array_host.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data (dropped if full and not popping)
//   push_data  : word to store
//   pop        : remove the head word (ignored when empty)
//   head       : current head word, 0 while empty
//   full/empty : occupancy flags
//   drop       : a push was refused this cycle because the FIFO was full
module fir_host_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  // The extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on an empty FIFO is ignored, so an empty push+pop is push only.
  // When full, a simultaneous pop frees the slot the push is about to reuse.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_array_host.sv
// Host endpoint of the nibble-serial Rdy/Vld systolic FIR array.
//   s_valid/s_ready/s_data : parallel sample input (valid/ready)
//   arr_rdy/arr_xin/arr_yin: frame to the first PE (Yin is always 0)
//   arr_vld/arr_xout/arr_yout: frame from the last PE
//   m_valid/m_ready/m_data : parallel result output from the FIFO head
//   ovf  : sticky, a completed result was dropped on a full FIFO
//   ferr : sticky, an incoming frame ended before NF nibbles
// Frames are NF = Y_W/4 consecutive strobe cycles, least-significant nibble
// first. Y_W must give NF >= 2.
module fir_array_host
  import fir_host_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int Y_W   = 16,
  parameter int GAP   = 1,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [X_W-1:0] s_data,
  output logic           arr_rdy,
  output nibble_t        arr_xin,
  output nibble_t        arr_yin,
  input  logic           arr_vld,
  input  nibble_t        arr_xout,
  input  nibble_t        arr_yout,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [Y_W-1:0] m_data,
  output logic           ovf,
  output logic           ferr
);

  localparam int NF     = calc_nf(Y_W);
  localparam int CNT_W  = (NF > 1) ? $clog2(NF) : 1;
  localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

  // ---------------- transmit ----------------
  tx_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [GCNT_W-1:0]  gcnt;
  logic [Y_W-1:0]     tx_shift;   // nibbles still to send, next one at the bottom

  assign arr_yin = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      tx_shift <= '0;
      s_ready  <= 1'b0;
      arr_rdy  <= 1'b0;
      arr_xin  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            // Nibble 0 goes out next cycle; the zero-extended rest is queued.
            state    <= SEND;
            cnt      <= '0;
            s_ready  <= 1'b0;
            arr_rdy  <= 1'b1;
            arr_xin  <= s_data[NIB_W-1:0];
            tx_shift <= Y_W'(s_data) >> NIB_W;
          end else begin
            s_ready <= 1'b1;
          end
        end
        SEND: begin
          if (cnt == CNT_W'(NF - 1)) begin
            state   <= GAPW;
            gcnt    <= '0;
            arr_rdy <= 1'b0;
            arr_xin <= '0;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            arr_xin  <= tx_shift[NIB_W-1:0];
            tx_shift <= tx_shift >> NIB_W;
          end
        end
        GAPW: begin
          if (gcnt == GCNT_W'(GAP - 1)) begin
            state   <= IDLE;
            s_ready <= 1'b1;
          end else begin
            gcnt <= gcnt + GCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- receive ----------------
  logic [CNT_W-1:0]     rcnt;
  logic [Y_W-NIB_W-1:0] asm_q;      // first NF-1 nibbles, oldest at the bottom
  logic [Y_W-1:0]       frame_word; // complete word once the last nibble arrives
  logic                 push;
  logic                 drop;
  logic                 full;
  logic                 empty;

  assign frame_word = {arr_yout, asm_q};
  assign push       = arr_vld && (rcnt == CNT_W'(NF - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt  <= '0;
      asm_q <= '0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (arr_vld) begin
        asm_q <= frame_word[Y_W-1:NIB_W];
        rcnt  <= push ? '0 : rcnt + CNT_W'(1);
        // The echoed sample is zero-padded above X_W, so those nibbles must
        // come back as zero from the last PE.
        if (int'(rcnt) >= X_W / NIB_W) assert (arr_xout == '0);
      end else if (rcnt != '0) begin
        ferr <= 1'b1;
        rcnt <= '0;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  fir_host_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (Y_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (frame_word),
    .pop       (m_ready),
    .head      (m_data),
    .full      (full),
    .empty     (empty),
    .drop      (drop)
  );

  assign m_valid = !empty;

endmodule
